// File: rtl/uart_tx_fifo_if.sv
// Byte push handshake into the UART TX FIFO.
// Upstream logic drives the master side; the FIFO is the slave.
interface uart_tx_fifo_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO.
// Frames go out LSB-first, WAIT_CYCLES clocks per bit, with no gap between back-to-back frames.
module uart_tx_fifo #(
    parameter int WAIT_CYCLES = 234,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_tx_fifo_if.slave                 up,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(WAIT_CYCLES);
    localparam logic [TW-1:0] T_END   = TW'(WAIT_CYCLES - 1);
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count_q;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            push, pop, fifo_nonempty, timer_end;

    assign up.tx_ready    = (count_q < DEPTH_C);
    assign push           = up.tx_valid && up.tx_ready;
    assign fifo_nonempty  = (count_q != '0);
    assign timer_end      = (timer_q == T_END);

    assign uart_tx    = tx_q;
    assign busy       = (state_q != IDLE) || fifo_nonempty;
    assign fifo_count = count_q;

    // Pointers wrap naturally since FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= up.tx_data;
    end

    // Pop decisions use the pre-edge count, so a push landing on the
    // stop-bit-end edge into an empty FIFO waits for the IDLE pop.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        if (state_q != IDLE)
            timer_d = timer_end ? '0 : timer_q + TW'(1);
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    tx_d    = 1'b0;
                    timer_d = '0;
                    state_d = START;
                end
            end
            START: begin
                if (timer_end) begin
                    tx_d    = shift_q[0];
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (timer_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        tx_d  = shift_q[1];
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (timer_end) begin
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted bytes are queued, and a line
// monitor decodes each frame and compares it against the queue head.
module tb_uart_tx_fifo;
    localparam int W = 4;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_tx, busy;
    logic [2:0] fifo_count;

    uart_tx_fifo_if bus();

    uart_tx_fifo #(.WAIT_CYCLES(W), .FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .up         (bus),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Line monitor: samples on negedge, W samples per bit, first sample defines the bit.
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    logic [9:0] mon_frame;
    int mon_s = -1;
    int mon_glitch = 0;
    int gap = 1;
    int frames_done = 0;
    int nogap_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            mon_s = -1;
            gap   = 1;
        end else if (mon_s < 0) begin
            if (uart_tx === 1'b0) begin
                if (gap == 0) nogap_cnt++;
                mon_frame  = '0;
                mon_glitch = 0;
                mon_s      = 1;
            end else begin
                gap++;
            end
        end else begin
            if (mon_s % W == 0) mon_frame[mon_s / W] = uart_tx;
            else if (uart_tx !== mon_frame[mon_s / W]) mon_glitch++;
            mon_s++;
            if (mon_s == 10 * W) begin
                frames_done++;
                if (exp_q.size() == 0) begin
                    chk("extra_frame", 32'd1, 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("frame", 32'(mon_frame), 32'({1'b1, mon_exp, 1'b0}));
                end
                chk("bit_hold", 32'(mon_glitch), 32'd0);
                mon_s = -1;
                gap   = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds tx_valid until the byte is accepted; acc is the cycle count of the accepting edge.
    task automatic push_byte(input logic [7:0] b, output int acc);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.tx_ready) begin
                exp_q.push_back(b);
                step();
                acc = cyc;
                return;
            end
            step();
        end
        chk("push_timeout", 32'd1, 32'd0);
    endtask

    task automatic drop();
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            if (!busy && mon_s < 0 && exp_q.size() == 0) return;
            step();
        end
        chk("idle_timeout", 32'd1, 32'd0);
    endtask

    int k1, k2, k3, k4, k6, f0, n0;
    int low_seen;

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;

        // Reset held two cycles
        rst = 1'b1;
        step();
        step();
        chk("rst_tx", 32'(uart_tx), 32'd1);
        chk("rst_ready", 32'(bus.tx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(fifo_count), 32'd0);
        rst = 1'b0;
        step();

        // Single byte, exact timing
        f0 = frames_done;
        push_byte(8'h55, k1);
        drop();
        chk("t2_cnt_k", 32'(fifo_count), 32'd1);
        chk("t2_tx_k", 32'(uart_tx), 32'd1);
        chk("t2_busy_k", 32'(busy), 32'd1);
        step();
        chk("t2_tx_k1", 32'(uart_tx), 32'd0);
        chk("t2_cnt_k1", 32'(fifo_count), 32'd0);
        repeat (39) step();
        chk("t2_busy_k40", 32'(busy), 32'd1);
        chk("t2_stop_k40", 32'(uart_tx), 32'd1);
        step();
        chk("t2_busy_k41", 32'(busy), 32'd0);
        chk("t2_frames", 32'(frames_done - f0), 32'd1);
        repeat (3) step();

        // Back-to-back frames
        f0 = frames_done;
        n0 = nogap_cnt;
        push_byte(8'hA5, k1);
        push_byte(8'h3C, k2);
        drop();
        wait_idle();
        chk("t3_len", 32'(cyc - k1 - 1), 32'd80);
        chk("t3_frames", 32'(frames_done - f0), 32'd2);
        chk("t3_nogap", 32'(nogap_cnt - n0), 32'd1);
        repeat (3) step();

        // Fill the FIFO, sixth byte held off until the first stop bit ends
        f0 = frames_done;
        n0 = nogap_cnt;
        push_byte(8'($urandom), k1);
        for (int i = 0; i < 4; i++) push_byte(8'($urandom), k2);
        chk("t4_cnt_full", 32'(fifo_count), 32'd4);
        chk("t4_ready_full", 32'(bus.tx_ready), 32'd0);
        push_byte(8'($urandom), k6);
        drop();
        chk("t4_hold", 32'(k6 - k1), 32'd42);
        wait_idle();
        chk("t4_frames", 32'(frames_done - f0), 32'd6);
        chk("t4_nogap", 32'(nogap_cnt - n0), 32'd5);
        repeat (3) step();

        // Push on the stop-bit-end edge with two bytes queued
        f0 = frames_done;
        n0 = nogap_cnt;
        push_byte(8'h81, k1);
        push_byte(8'h42, k2);
        push_byte(8'h24, k3);
        drop();
        repeat (38) step();
        chk("t5_cnt_pre", 32'(fifo_count), 32'd2);
        push_byte(8'h18, k4);
        drop();
        chk("t5_edge", 32'(k4 - k1), 32'd41);
        chk("t5_cnt_post", 32'(fifo_count), 32'd2);
        chk("t5_start", 32'(uart_tx), 32'd0);
        wait_idle();
        chk("t5_frames", 32'(frames_done - f0), 32'd4);
        chk("t5_nogap", 32'(nogap_cnt - n0), 32'd3);
        repeat (3) step();

        // Reset during data bit 3 of 0xFF with two bytes queued
        push_byte(8'hFF, k1);
        push_byte(8'h11, k2);
        push_byte(8'h22, k3);
        drop();
        repeat (15) step();
        chk("t6_cnt_pre", 32'(fifo_count), 32'd2);
        rst = 1'b1;
        step();
        exp_q.delete();
        chk("t6_tx", 32'(uart_tx), 32'd1);
        chk("t6_cnt", 32'(fifo_count), 32'd0);
        chk("t6_ready", 32'(bus.tx_ready), 32'd1);
        chk("t6_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        f0 = frames_done;
        low_seen = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (uart_tx !== 1'b1) low_seen++;
        end
        chk("t6_quiet", 32'(low_seen), 32'd0);
        chk("t6_noframes", 32'(frames_done - f0), 32'd0);
        push_byte(8'h01, k1);
        drop();
        wait_idle();
        chk("t6_after", 32'(frames_done - f0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
